// File: rtl/alu_op_sequencer_pkg.sv
// Shared types for the ALU command sequencer: opcodes, FSM states, the command record
// and the error decode used when a command is issued.
package alu_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_MUL = 4'd2,
        ALU_DIV = 4'd3
    } alu_sel_e;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_EXEC = 2'd1,
        SEQ_RESP = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [3:0]       sel;
    } alu_cmd_t;

    // Divide by zero and any opcode beyond DIV are reported as errors.
    function automatic logic cmdIsErr(alu_cmd_t cmd);
        return ((cmd.sel == ALU_DIV) && (cmd.b == '0)) || (cmd.sel > ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU and response signals of the sequencer; the slave modport is the
// sequencer's view, the master modport is the surrounding system's view.
interface alu_op_sequencer_if #(
    parameter int W     = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_a;
    logic [W-1:0]  cmd_b;
    logic [3:0]    cmd_sel;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [3:0]    alu_sel;
    logic [W-1:0]  alu_out;
    logic          alu_carry;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          rsp_carry;
    logic          rsp_err;
    logic [CW-1:0] fifo_count;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, alu_carry, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_carry,
               rsp_err, fifo_count
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, alu_carry, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_carry,
               rsp_err, fifo_count
    );

endinterface

// File: rtl/alu_op_sequencer_fifo.sv
// Synchronous command FIFO (alu_cmd_fifo) holding alu_cmd_t records; DEPTH must be a
// power of two so the pointers wrap naturally.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  alu_cmd_t               data_i,
    output alu_cmd_t               data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    alu_cmd_t      mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [AW:0]   count_q;
    logic          doPush;
    logic          doPop;

    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clock) begin
        if (doPush) mem_q[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Feeds buffered commands to the registered ALU one at a time and returns each result.
// Optional build macro ALU_SEQ_ERR_BYPASS_EN: error ops skip the ALU and answer with zero data.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input logic                clock,
    input logic                reset,
    alu_op_sequencer_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    seq_state_e    state_q, state_d;
    logic [W-1:0]  aluA_q, aluA_d;
    logic [W-1:0]  aluB_q, aluB_d;
    logic [3:0]    aluSel_q, aluSel_d;
    logic          err_q, err_d;

    alu_cmd_t      pushCmd;
    alu_cmd_t      headCmd;
    logic          fifoFull;
    logic          fifoEmpty;
    logic          popHead;
    logic          canIssue;
    logic [CW-1:0] count;

    assign pushCmd.a   = bus.cmd_a;
    assign pushCmd.b   = bus.cmd_b;
    assign pushCmd.sel = bus.cmd_sel;

    assign bus.cmd_ready  = !fifoFull && !reset;
    assign bus.alu_a      = aluA_q;
    assign bus.alu_b      = aluB_q;
    assign bus.alu_sel    = aluSel_q;
    assign bus.fifo_count = count;

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (bus.cmd_valid && bus.cmd_ready),
        .pop_i   (popHead),
        .data_i  (pushCmd),
        .data_o  (headCmd),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= SEQ_IDLE;
            aluA_q   <= '0;
            aluB_q   <= '0;
            aluSel_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            aluA_q   <= aluA_d;
            aluB_q   <= aluB_d;
            aluSel_q <= aluSel_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        aluA_d        = aluA_q;
        aluB_d        = aluB_q;
        aluSel_d      = aluSel_q;
        err_d         = err_q;
        popHead       = 1'b0;
        canIssue      = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        bus.rsp_carry = 1'b0;
        bus.rsp_err   = 1'b0;

        case (state_q)
            SEQ_IDLE: canIssue = !fifoEmpty;
            SEQ_EXEC: state_d = SEQ_RESP;
            SEQ_RESP: begin
                if (bus.rsp_ready) begin
                    state_d  = SEQ_IDLE;
                    canIssue = !fifoEmpty;
                end
            end
            default:  state_d = SEQ_IDLE;
        endcase

        // ALU inputs only move on issue, so alu_out stays put while a response waits.
        if (canIssue) begin
            popHead = 1'b1;
            err_d   = cmdIsErr(headCmd);
`ifdef ALU_SEQ_ERR_BYPASS_EN
            if (cmdIsErr(headCmd)) begin
                state_d = SEQ_RESP;
            end else begin
                aluA_d   = headCmd.a;
                aluB_d   = headCmd.b;
                aluSel_d = headCmd.sel;
                state_d  = SEQ_EXEC;
            end
`else
            aluA_d   = headCmd.a;
            aluB_d   = headCmd.b;
            aluSel_d = headCmd.sel;
            state_d  = SEQ_EXEC;
`endif
        end

        if (state_q == SEQ_RESP) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_err   = err_q;
`ifdef ALU_SEQ_ERR_BYPASS_EN
            if (!err_q) begin
                bus.rsp_data  = bus.alu_out;
                bus.rsp_carry = bus.alu_carry;
            end
`else
            bus.rsp_data  = bus.alu_out;
            bus.rsp_carry = bus.alu_carry;
`endif
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised self-checking bench for alu_op_sequencer with a registered ALU stub and a
// response model derived from the opcode rules; honours ALU_SEQ_ERR_BYPASS_EN.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [W-1:0] data;
        logic         carry;
        logic         err;
    } rsp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [W-1:0] aluOut;
    logic         aluCarry;

    int   checks  = 0;
    int   fails   = 0;
    int   cycleNo = 0;
    rsp_t gotQ[$];
    int   rspCycles[$];

    alu_op_sequencer_if #(.W(W), .DEPTH(DEPTH)) bus ();

    alu_op_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic int aluValue(int a, int b, int sel);
        case (sel)
            0:       return (a + b) % (1 << W);
            1:       return (a - b + (1 << W)) % (1 << W);
            2:       return (a * b) % (1 << W);
            3:       return (b == 0) ? (1 << W) - 1 : a / b;
            default: return 0;
        endcase
    endfunction

    // Registered ALU stub: captures whatever sits on its inputs every rising edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aluOut   <= '0;
            aluCarry <= 1'b0;
        end else begin
            aluOut   <= W'(aluValue(int'(bus.alu_a), int'(bus.alu_b), int'(bus.alu_sel)));
            aluCarry <= (int'(bus.alu_a) + int'(bus.alu_b)) >= (1 << W);
        end
    end

    assign bus.alu_out   = aluOut;
    assign bus.alu_carry = aluCarry;

    function automatic rsp_t expectRsp(alu_cmd_t c);
        rsp_t r;
        int   a;
        int   b;
        int   sel;
        bit   isErr;
        a       = int'(c.a);
        b       = int'(c.b);
        sel     = int'(c.sel);
        isErr   = (sel == 3 && b == 0) || sel > 3;
        r.data  = W'(aluValue(a, b, sel));
        r.carry = (a + b) >= (1 << W);
        r.err   = isErr;
`ifdef ALU_SEQ_ERR_BYPASS_EN
        if (isErr) begin
            r.data  = '0;
            r.carry = 1'b0;
        end
`endif
        return r;
    endfunction

    function automatic alu_cmd_t randCmd(bit allowErr);
        alu_cmd_t c;
        c.a   = W'($urandom);
        c.b   = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
        c.sel = allowErr ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 3));
        if (!allowErr && c.sel == 4'd3 && c.b == '0) c.b = 8'd7;
        return c;
    endfunction

    function automatic alu_cmd_t mkCmd(logic [W-1:0] a, logic [W-1:0] b, logic [3:0] sel);
        alu_cmd_t c;
        c.a   = a;
        c.b   = b;
        c.sel = sel;
        return c;
    endfunction

    task automatic applyStimulus(alu_cmd_t c);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = c.a;
        bus.cmd_b     = c.b;
        bus.cmd_sel   = c.sel;
    endtask

    // Records any response handshake happening on the coming edge, then moves 1ns past it.
    task automatic tick();
        if (bus.rsp_valid && bus.rsp_ready) begin
            gotQ.push_back({bus.rsp_data, bus.rsp_carry, bus.rsp_err});
            rspCycles.push_back(cycleNo);
        end
        @(posedge clock);
        #1;
        cycleNo++;
    endtask

    task automatic runUntilResponses(int n, int budget);
        for (int k = 0; k < budget && gotQ.size() < n; k++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.cmd_sel = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_valid got %0h want 0", bus.rsp_valid); end
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== '0) begin fails++; $display("[TB] FAIL reset_alu_regs got %0h/%0h/%0h want 0", bus.alu_a, bus.alu_b, bus.alu_sel); end
        checks++; if ({bus.rsp_data, bus.rsp_carry, bus.rsp_err} !== '0) begin fails++; $display("[TB] FAIL reset_rsp_fields got %0h/%0h/%0h want 0", bus.rsp_data, bus.rsp_carry, bus.rsp_err); end
        checks++; if (bus.fifo_count !== 3'd0) begin fails++; $display("[TB] FAIL reset_fifo_count got %0d want 0", bus.fifo_count); end
        reset = 1'b0;
        #1;
        checks++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_cmd_ready got %0h want 1", bus.cmd_ready); end
    endtask

    task automatic test_add_latency();
        alu_cmd_t c;
        c = mkCmd(8'd200, 8'd100, 4'd0);
        gotQ.delete();
        bus.rsp_ready = 1'b1;
        applyStimulus(c);
        tick();
        bus.cmd_valid = 1'b0;
        checks++; if (bus.fifo_count !== 3'd1) begin fails++; $display("[TB] FAIL add_count_after_push got %0d want 1", bus.fifo_count); end
        checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL add_valid_t0 got %0h want 0", bus.rsp_valid); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL add_valid_t1 got %0h want 0", bus.rsp_valid); end
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== {c.a, c.b, c.sel}) begin fails++; $display("[TB] FAIL add_issue got %0h/%0h/%0h want %0h/%0h/%0h", bus.alu_a, bus.alu_b, bus.alu_sel, c.a, c.b, c.sel); end
        checks++; if (bus.fifo_count !== 3'd0) begin fails++; $display("[TB] FAIL add_count_after_pop got %0d want 0", bus.fifo_count); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL add_valid_t2 got %0h want 1", bus.rsp_valid); end
        checks++; if ({bus.rsp_data, bus.rsp_carry, bus.rsp_err} !== {8'h2C, 1'b1, 1'b0}) begin fails++; $display("[TB] FAIL add_result got %0h/%0h/%0h want 2c/1/0", bus.rsp_data, bus.rsp_carry, bus.rsp_err); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL add_valid_after_accept got %0h want 0", bus.rsp_valid); end
        checks++; if (gotQ.size() !== 1) begin fails++; $display("[TB] FAIL add_rsp_count got %0d want 1", gotQ.size()); end
    endtask

    task automatic test_div_zero();
        alu_cmd_t c;
        rsp_t     exp;
        c = mkCmd(8'd10, 8'd0, 4'd3);
        exp = expectRsp(c);
        gotQ.delete();
        bus.rsp_ready = 1'b1;
        applyStimulus(c);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
`ifdef ALU_SEQ_ERR_BYPASS_EN
        checks++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL div0_bypass_valid_t1 got %0h want 1", bus.rsp_valid); end
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== {8'd200, 8'd100, 4'd0}) begin fails++; $display("[TB] FAIL div0_bypass_alu_held got %0h/%0h/%0h want c8/64/0", bus.alu_a, bus.alu_b, bus.alu_sel); end
`else
        checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL div0_valid_t1 got %0h want 0", bus.rsp_valid); end
        checks++; if ({bus.alu_b, bus.alu_sel} !== {8'd0, 4'd3}) begin fails++; $display("[TB] FAIL div0_issue got %0h/%0h want 0/3", bus.alu_b, bus.alu_sel); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL div0_valid_t2 got %0h want 1", bus.rsp_valid); end
`endif
        checks++; if ({bus.rsp_data, bus.rsp_carry, bus.rsp_err} !== exp) begin fails++; $display("[TB] FAIL div0_result got %0h/%0h/%0h want %0h", bus.rsp_data, bus.rsp_carry, bus.rsp_err, exp); end
        tick();
        checks++; if (gotQ.size() !== 1) begin fails++; $display("[TB] FAIL div0_rsp_count got %0d want 1", gotQ.size()); end
    endtask

    task automatic test_backpressure();
        alu_cmd_t cmds[6];
        int       idx;
        logic     accepted;
        idx = 0;
        for (int i = 0; i < 6; i++) cmds[i] = randCmd(1'b1);
        gotQ.delete();
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (idx < 6) applyStimulus(cmds[idx]);
            else bus.cmd_valid = 1'b0;
            accepted = bus.cmd_valid && bus.cmd_ready;
            tick();
            if (accepted) idx++;
        end
        checks++; if (idx !== 5) begin fails++; $display("[TB] FAIL bp_accept_count got %0d want 5", idx); end
        checks++; if (bus.cmd_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_cmd_ready got %0h want 0", bus.cmd_ready); end
        checks++; if (bus.fifo_count !== 3'(DEPTH)) begin fails++; $display("[TB] FAIL bp_fifo_count got %0d want %0d", bus.fifo_count, DEPTH); end
        for (int k = 0; k < 3; k++) begin
            checks++; if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, expectRsp(cmds[0]).data}) begin fails++; $display("[TB] FAIL bp_hold_%0d got %0h/%0h want 1/%0h", k, bus.rsp_valid, bus.rsp_data, expectRsp(cmds[0]).data); end
            tick();
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        runUntilResponses(5, 40);
        checks++; if (gotQ.size() !== 5) begin fails++; $display("[TB] FAIL bp_drain_count got %0d want 5", gotQ.size()); end
        for (int i = 0; i < 5 && i < gotQ.size(); i++) begin
            checks++; if (gotQ[i] !== expectRsp(cmds[i])) begin fails++; $display("[TB] FAIL bp_rsp_%0d got %0h want %0h", i, gotQ[i], expectRsp(cmds[i])); end
        end
    endtask

    task automatic test_back_to_back();
        alu_cmd_t cmds[4];
        int       acc;
        acc = 0;
        for (int i = 0; i < 4; i++) cmds[i] = randCmd(1'b0);
        gotQ.delete();
        rspCycles.delete();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(cmds[i]);
            if (bus.cmd_ready) acc++;
            tick();
        end
        bus.cmd_valid = 1'b0;
        checks++; if (acc !== 4) begin fails++; $display("[TB] FAIL b2b_accepts got %0d want 4", acc); end
        runUntilResponses(4, 30);
        checks++; if (gotQ.size() !== 4) begin fails++; $display("[TB] FAIL b2b_rsp_count got %0d want 4", gotQ.size()); end
        for (int i = 0; i < 4 && i < gotQ.size(); i++) begin
            checks++; if (gotQ[i] !== expectRsp(cmds[i])) begin fails++; $display("[TB] FAIL b2b_rsp_%0d got %0h want %0h", i, gotQ[i], expectRsp(cmds[i])); end
            if (i > 0) begin
                checks++; if (rspCycles[i] - rspCycles[i-1] !== 2) begin fails++; $display("[TB] FAIL b2b_spacing_%0d got %0d want 2", i, rspCycles[i] - rspCycles[i-1]); end
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        int seen;
        seen = 0;
        bus.rsp_ready = 1'b1;
        applyStimulus(mkCmd(8'h5A, 8'h33, 4'd0));
        tick();
        applyStimulus(mkCmd(8'h11, 8'h22, 4'd1));
        tick();
        bus.cmd_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_valid got %0h want 0", bus.rsp_valid); end
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== '0) begin fails++; $display("[TB] FAIL mid_reset_alu got %0h/%0h/%0h want 0", bus.alu_a, bus.alu_b, bus.alu_sel); end
        checks++; if (bus.fifo_count !== 3'd0) begin fails++; $display("[TB] FAIL mid_reset_count got %0d want 0", bus.fifo_count); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        gotQ.delete();
        for (int k = 0; k < 6; k++) begin
            if (bus.rsp_valid) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin fails++; $display("[TB] FAIL mid_reset_stale_rsp got %0d want 0", seen); end
        checks++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL mid_reset_cmd_ready got %0h want 1", bus.cmd_ready); end
    endtask

    task automatic test_push_pop_same();
        alu_cmd_t cmds[5];
        for (int i = 0; i < 5; i++) cmds[i] = randCmd(1'b1);
        gotQ.delete();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(cmds[i]);
            tick();
        end
        checks++; if (bus.fifo_count !== 3'(DEPTH - 1)) begin fails++; $display("[TB] FAIL pp_count_before got %0d want %0d", bus.fifo_count, DEPTH - 1); end
        checks++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL pp_valid_before got %0h want 1", bus.rsp_valid); end
        applyStimulus(cmds[4]);
        bus.rsp_ready = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        checks++; if (bus.fifo_count !== 3'(DEPTH - 1)) begin fails++; $display("[TB] FAIL pp_count_after got %0d want %0d", bus.fifo_count, DEPTH - 1); end
        runUntilResponses(5, 40);
        checks++; if (gotQ.size() !== 5) begin fails++; $display("[TB] FAIL pp_drain_count got %0d want 5", gotQ.size()); end
        for (int i = 0; i < 5 && i < gotQ.size(); i++) begin
            checks++; if (gotQ[i] !== expectRsp(cmds[i])) begin fails++; $display("[TB] FAIL pp_rsp_%0d got %0h want %0h", i, gotQ[i], expectRsp(cmds[i])); end
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_div_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_exec();
        test_push_pop_same();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
